// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM line decoder recovering the pulse-width code of each frame
module pwm_capture #(
  parameter int WIDTH = 12,
  parameter int DIV   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] pw_out,
  output logic             pw_valid,
  output logic             pw_changed,
  output logic             static_flag
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RELOAD_I = DIV - 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = RELOAD_I[PRE_W-1:0];
  localparam logic [WIDTH-1:0] SLOT_LAST = '1;

  logic             s1;
  logic             s2;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             frame_end;
  logic [WIDTH-1:0] slot_cnt;
  logic [WIDTH:0]   high_cnt;
  logic [WIDTH:0]   total;
  logic [WIDTH-1:0] new_pw;

  assign tick      = en && (pre == '0);
  assign frame_end = tick && (slot_cnt == SLOT_LAST);
  assign total     = high_cnt + {{WIDTH{1'b0}}, s2};
  // total never exceeds 2^WIDTH, so its top bit alone marks an all-high frame
  assign new_pw    = total[WIDTH] ? '1 : total[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= PRE_RELOAD;
    end else if (!en || (pre == '0)) begin
      pre <= PRE_RELOAD;
    end else begin
      pre <= pre - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      high_cnt <= '0;
    end else if (!en) begin
      slot_cnt <= '0;
      high_cnt <= '0;
    end else if (tick) begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        high_cnt <= '0;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
        high_cnt <= total;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw_out      <= '0;
      static_flag <= 1'b0;
      pw_valid    <= 1'b0;
      pw_changed  <= 1'b0;
    end else begin
      pw_valid   <= frame_end;
      pw_changed <= frame_end && (new_pw != pw_out);
      if (frame_end) begin
        pw_out      <= new_pw;
        static_flag <= (total == '0) || total[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized self-checking bench for pwm_capture
module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // u[0]: WIDTH=12 DIV=3, u[1]: WIDTH=4 DIV=1
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 0) ? 12 : 4;
    localparam int D = (g == 0) ? 3 : 1;
    localparam int N = 1 << W;

    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         line = 1'b0;
    logic [W-1:0] pw;
    logic         valid;
    logic         changed;
    logic         stat;

    pwm_capture #(.WIDTH(W), .DIV(D)) dut (
      .clk(clk), .rst(rst), .en(en), .pwm_in(line),
      .pw_out(pw), .pw_valid(valid), .pw_changed(changed), .static_flag(stat)
    );

    // free-running generator: high for the first gen_code slots, code N-1 forced high
    int gen_mode = 0;
    int gen_level = 0;
    int gen_code = 0;
    int gen_slot = 0;
    int gen_pre = 0;
    always @(negedge clk) begin
      if (gen_pre == 0) begin
        gen_pre  = D - 1;
        gen_slot = (gen_slot + 1) % N;
      end else begin
        gen_pre = gen_pre - 1;
      end
      if (gen_mode == 0) line = gen_level[0];
      else line = (gen_code == N - 1) || (gen_slot < gen_code);
    end

    // reference: a frame closes every N*D enabled clocks; its width is the number of
    // high line values seen two clocks before each slot end (zero before a reset)
    bit           hist [0:131071];
    int           nedge = 0;
    int           first_live = 1;
    int           run = 0;
    logic [W-1:0] exp_pw = '0;
    logic         exp_valid = 1'b0;
    logic         exp_changed = 1'b0;
    logic         exp_stat = 1'b0;

    always @(posedge rst) begin
      run = 0;
      exp_pw = '0;
      exp_valid = 1'b0;
      exp_changed = 1'b0;
      exp_stat = 1'b0;
      first_live = nedge + 1;
    end

    always @(posedge clk) begin : model_step
      int total;
      int idx;
      logic [W-1:0] npw;
      nedge = nedge + 1;
      hist[nedge] = rst ? 1'b0 : line;
      exp_valid = 1'b0;
      exp_changed = 1'b0;
      if (rst || !en) begin
        run = 0;
      end else begin
        run = run + 1;
        if (run == N * D) begin
          total = 0;
          for (int i = 1; i <= N; i++) begin
            idx = nedge - N * D + i * D - 2;
            if (idx >= first_live && idx >= 1 && hist[idx]) total = total + 1;
          end
          if (total >= N) npw = '1;
          else npw = total[W-1:0];
          exp_valid = 1'b1;
          exp_changed = (npw != exp_pw);
          exp_pw = npw;
          exp_stat = (total == 0) || (total == N);
          run = 0;
        end
      end
    end
  end

  task automatic test_reset();
    logic want;
    u[0].rst = 1'b1; u[0].en = 1'b1; u[0].gen_mode = 0; u[0].gen_level = 0;
    u[1].rst = 1'b1; u[1].en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({u[0].pw, u[0].valid, u[0].changed, u[0].stat} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state_a: got pw=%0d v=%b c=%b s=%b want all 0", u[0].pw, u[0].valid, u[0].changed, u[0].stat);
    end
    vectors++;
    if ({u[1].pw, u[1].valid, u[1].changed, u[1].stat} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_state_b: got pw=%0d v=%b c=%b s=%b want all 0", u[1].pw, u[1].valid, u[1].changed, u[1].stat);
    end
    u[0].rst = 1'b0;
    for (int c = 1; c <= 2 * 12288 + 8; c++) begin
      @(negedge clk);
      want = (c == 12288) || (c == 24576);
      vectors++;
      if (u[0].valid !== want) begin
        miscompares++;
        $display("FAIL reset_frame_timing: cycle %0d pw_valid=%b want %b", c, u[0].valid, want);
      end
      if (u[0].valid) begin
        vectors++;
        if (u[0].pw !== 12'd0 || u[0].stat !== 1'b1 || u[0].changed !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_frame_value: pw=%0d s=%b c=%b want pw=0 s=1 c=0", u[0].pw, u[0].stat, u[0].changed);
        end
      end
    end
  endtask

  task automatic test_loopback_a();
    int frames = 0;
    u[0].en = 1'b0;
    u[0].gen_slot = $urandom_range(0, 4095);
    u[0].gen_pre = $urandom_range(0, 2);
    u[0].gen_code = 1000;
    u[0].gen_mode = 1;
    repeat (5) @(negedge clk);
    u[0].en = 1'b1;
    for (int c = 1; c <= 2 * 12288 + 2; c++) begin
      @(negedge clk);
      vectors++;
      if (u[0].valid !== u[0].exp_valid || u[0].pw !== u[0].exp_pw || u[0].changed !== u[0].exp_changed || u[0].stat !== u[0].exp_stat) begin
        miscompares++;
        $display("FAIL loopback_model: cycle %0d got v=%b pw=%0d c=%b s=%b want v=%b pw=%0d c=%b s=%b", c, u[0].valid, u[0].pw, u[0].changed, u[0].stat, u[0].exp_valid, u[0].exp_pw, u[0].exp_changed, u[0].exp_stat);
      end
      if (u[0].valid) begin
        frames++;
        vectors++;
        if (u[0].pw !== 12'd1000 || u[0].stat !== 1'b0 || u[0].changed !== (frames == 1)) begin
          miscompares++;
          $display("FAIL loopback_code: frame %0d pw=%0d s=%b c=%b want pw=1000 s=0 c=%b", frames, u[0].pw, u[0].stat, u[0].changed, frames == 1);
        end
      end
    end
    vectors++;
    if (frames !== 2) begin
      miscompares++;
      $display("FAIL loopback_frames: got %0d frames want 2", frames);
    end
  endtask

  task automatic test_enable_drop_a();
    int k = $urandom_range(1000, 3000);
    int code = $urandom_range(1, 4094);
    if (code == 1000) code = 1001;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      vectors++;
      if (u[0].valid !== 1'b0 || u[0].pw !== 12'd1000) begin
        miscompares++;
        $display("FAIL pre_drop_idle: cycle %0d v=%b pw=%0d want v=0 pw=1000", c, u[0].valid, u[0].pw);
      end
    end
    u[0].en = 1'b0;
    u[0].gen_code = code;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      vectors++;
      if (u[0].valid !== 1'b0 || u[0].changed !== 1'b0 || u[0].pw !== 12'd1000) begin
        miscompares++;
        $display("FAIL disabled_hold: cycle %0d v=%b c=%b pw=%0d want v=0 c=0 pw=1000", c, u[0].valid, u[0].changed, u[0].pw);
      end
    end
    u[0].en = 1'b1;
    for (int c = 1; c <= 12288 + 2; c++) begin
      @(negedge clk);
      vectors++;
      if (u[0].valid !== (c == 12288) || u[0].valid !== u[0].exp_valid) begin
        miscompares++;
        $display("FAIL reenable_timing: cycle %0d pw_valid=%b want %b", c, u[0].valid, c == 12288);
      end
      if (u[0].valid) begin
        vectors++;
        if (u[0].pw !== code[11:0] || u[0].stat !== 1'b0 || u[0].changed !== 1'b1) begin
          miscompares++;
          $display("FAIL reenable_code: pw=%0d s=%b c=%b want pw=%0d s=0 c=1", u[0].pw, u[0].stat, u[0].changed, code);
        end
      end
    end
  endtask

  task automatic test_async_reset_a();
    @(negedge clk);
    #2 u[0].rst = 1'b1;
    #1;
    vectors++;
    if ({u[0].pw, u[0].valid, u[0].changed, u[0].stat} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset_a: got pw=%0d v=%b c=%b s=%b want all 0 before clock", u[0].pw, u[0].valid, u[0].changed, u[0].stat);
    end
    #1 u[0].rst = 1'b0;
    u[0].en = 1'b0;
  endtask

  task automatic test_saturate_b();
    int k = $urandom_range(3, 12);
    u[1].gen_mode = 0;
    u[1].gen_level = 1;
    u[1].en = 1'b1;
    u[1].rst = 1'b0;
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      vectors++;
      if (u[1].valid !== (c % 16 == 0) || u[1].valid !== u[1].exp_valid || u[1].pw !== u[1].exp_pw || u[1].changed !== u[1].exp_changed || u[1].stat !== u[1].exp_stat) begin
        miscompares++;
        $display("FAIL saturate_model: cycle %0d got v=%b pw=%0d c=%b s=%b want v=%b pw=%0d c=%b s=%b", c, u[1].valid, u[1].pw, u[1].changed, u[1].stat, u[1].exp_valid, u[1].exp_pw, u[1].exp_changed, u[1].exp_stat);
      end
      if (c == 32 || c == 48) begin
        vectors++;
        if (u[1].pw !== 4'd15 || u[1].stat !== 1'b1) begin
          miscompares++;
          $display("FAIL saturate_high: cycle %0d pw=%0d s=%b want pw=15 s=1", c, u[1].pw, u[1].stat);
        end
      end
      if (c == 80) begin
        vectors++;
        if (u[1].pw !== 4'd1 || u[1].stat !== 1'b0 || u[1].changed !== 1'b1) begin
          miscompares++;
          $display("FAIL code_one: pw=%0d s=%b c=%b want pw=1 s=0 c=1", u[1].pw, u[1].stat, u[1].changed);
        end
      end
      if (c == 48 + k) begin
        u[1].gen_code = 1;
        u[1].gen_mode = 1;
      end
    end
  endtask

  task automatic test_code_change_b();
    int k = $urandom_range(3, 12);
    u[1].gen_code = 5;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      vectors++;
      if (u[1].valid !== (c % 16 == 0) || u[1].valid !== u[1].exp_valid || u[1].pw !== u[1].exp_pw || u[1].changed !== u[1].exp_changed || u[1].stat !== u[1].exp_stat) begin
        miscompares++;
        $display("FAIL code_change_model: cycle %0d got v=%b pw=%0d c=%b s=%b want v=%b pw=%0d c=%b s=%b", c, u[1].valid, u[1].pw, u[1].changed, u[1].stat, u[1].exp_valid, u[1].exp_pw, u[1].exp_changed, u[1].exp_stat);
      end
      if (c == 32 || c == 64 || c == 80) begin
        vectors++;
        if (u[1].pw !== ((c == 32) ? 4'd5 : 4'd11) || u[1].stat !== 1'b0) begin
          miscompares++;
          $display("FAIL code_change_exact: cycle %0d pw=%0d s=%b want pw=%0d s=0", c, u[1].pw, u[1].stat, (c == 32) ? 5 : 11);
        end
      end
      if (c == 48) begin
        vectors++;
        if (u[1].pw < 4'd5 || u[1].pw > 4'd11) begin
          miscompares++;
          $display("FAIL code_change_straddle: pw=%0d want within 5..11", u[1].pw);
        end
      end
      if (c == 80) begin
        vectors++;
        if (u[1].changed !== 1'b0) begin
          miscompares++;
          $display("FAIL code_change_steady: pw_changed=%b want 0", u[1].changed);
        end
      end
      if (c == 32 + k) u[1].gen_code = 11;
    end
  endtask

  task automatic test_enable_b();
    logic want;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      want = (c == 36) || (c == 52);
      vectors++;
      if (u[1].valid !== want || u[1].valid !== u[1].exp_valid) begin
        miscompares++;
        $display("FAIL enable_edge_timing: cycle %0d pw_valid=%b want %b", c, u[1].valid, want);
      end
      vectors++;
      if (u[1].pw !== 4'd11 || u[1].changed !== 1'b0) begin
        miscompares++;
        $display("FAIL enable_edge_hold: cycle %0d pw=%0d c=%b want pw=11 c=0", c, u[1].pw, u[1].changed);
      end
      if (c == 15) u[1].en = 1'b0;
      if (c == 20) u[1].en = 1'b1;
    end
  endtask

  task automatic test_midframe_reset_b();
    int k = $urandom_range(2, 12);
    repeat (k) @(negedge clk);
    #2 u[1].rst = 1'b1;
    #1;
    vectors++;
    if ({u[1].pw, u[1].valid, u[1].changed, u[1].stat} !== 7'd0) begin
      miscompares++;
      $display("FAIL async_reset_b: got pw=%0d v=%b c=%b s=%b want all 0 before clock", u[1].pw, u[1].valid, u[1].changed, u[1].stat);
    end
    #1 u[1].rst = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      vectors++;
      if (u[1].valid !== (c % 16 == 0) || u[1].valid !== u[1].exp_valid || u[1].pw !== u[1].exp_pw || u[1].changed !== u[1].exp_changed || u[1].stat !== u[1].exp_stat) begin
        miscompares++;
        $display("FAIL post_reset_model: cycle %0d got v=%b pw=%0d c=%b s=%b want v=%b pw=%0d c=%b s=%b", c, u[1].valid, u[1].pw, u[1].changed, u[1].stat, u[1].exp_valid, u[1].exp_pw, u[1].exp_changed, u[1].exp_stat);
      end
      if (c == 32 || c == 48) begin
        vectors++;
        if (u[1].pw !== 4'd11) begin
          miscompares++;
          $display("FAIL post_reset_code: cycle %0d pw=%0d want 11", c, u[1].pw);
        end
      end
    end
  endtask

  task automatic test_random_codes_b();
    int when = $urandom_range(0, 31);
    for (int c = 1; c <= 384; c++) begin
      @(negedge clk);
      vectors++;
      if (u[1].valid !== (c % 16 == 0) || u[1].valid !== u[1].exp_valid || u[1].pw !== u[1].exp_pw || u[1].changed !== u[1].exp_changed || u[1].stat !== u[1].exp_stat) begin
        miscompares++;
        $display("FAIL random_codes_model: cycle %0d got v=%b pw=%0d c=%b s=%b want v=%b pw=%0d c=%b s=%b", c, u[1].valid, u[1].pw, u[1].changed, u[1].stat, u[1].exp_valid, u[1].exp_pw, u[1].exp_changed, u[1].exp_stat);
      end
      if (c % 32 == when) begin
        u[1].gen_code = $urandom_range(0, 15);
        when = $urandom_range(0, 31);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback_a();
    test_enable_drop_a();
    test_async_reset_a();
    test_saturate_b();
    test_code_change_b();
    test_enable_b();
    test_midframe_reset_b();
    test_random_codes_b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Decoder counterpart of the team's 12-bit PWM generator: samples an incoming PWM line and recovers the 12-bit pulse-width code that produced it.
- Sits on the feedback/measurement path in the same clock domain as the generator, e.g. for loop-back checking or reading an external PWM source into the fuzzy controller.
- Uses the same slot timing as the generator (one slot = DIV clocks, one frame = 2^WIDTH slots), so a steady input decodes exactly, independent of phase.

Parameters:
- WIDTH, 12, code width; frame length = 2^WIDTH slots.
- DIV, 3, clocks per slot (prescaler divide ratio, >=1); must match the generator's slot length.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; low holds the block idle.
- pwm_in  input  1  PWM line, may be asynchronous to clk.
- pw_out  output  WIDTH  last decoded pulse width.
- pw_valid  output  1  one-cycle strobe: pw_out/static_flag updated.
- pw_changed  output  1  one-cycle strobe, coincident with pw_valid, when the new pw_out differs from the previous one.
- static_flag  output  1  last frame had constant level (all-low or all-high).

Behaviour:
- Reset (async, rst=1): pw_out=0, pw_valid=0, pw_changed=0, static_flag=0. Synchroniser flops=0, prescaler=DIV-1, slot_cnt=0, high_cnt=0.
- Synchroniser: two flops, pwm_in -> s1 -> s2. Only s2 is used. Fixed 2-cycle input latency.
- Prescaler: down-counter pre. When en=1 it decrements each clock. When pre==0, tick=1 and pre reloads DIV-1. The first tick occurs DIV clocks after reset release or en rise. DIV=1 gives a tick every clock.
- On each tick: slot_cnt increments (WIDTH bits) and high_cnt (WIDTH+1 bits) adds s2.
- Frame close, on the tick where slot_cnt==2^WIDTH-1:
  - total = high_cnt + s2.
  - pw_out <= (total==2^WIDTH) ? 2^WIDTH-1 : total. This saturates; constant high decodes to 4095, matching the generator's forced-high code.
  - static_flag <= (total==0) || (total==2^WIDTH).
  - pw_changed <= (new pw_out != old pw_out).
  - pw_valid <= 1 for exactly the next cycle.
  - slot_cnt wraps to 0 and high_cnt <= 0.
- Strobe timing: pw_valid and pw_changed are registered and asserted in the cycle after the closing tick. They are low in every other cycle.
- Frame period: pw_valid repeats every DIV*2^WIDTH clocks while en=1.
- en=0: prescaler held at DIV-1; slot_cnt and high_cnt cleared; synchroniser keeps running. pw_out and static_flag hold their last values. Strobes are forced 0.
- en rising: a fresh frame starts. The first pw_valid arrives DIV*2^WIDTH clocks after the first post-enable clock. A partial frame is never reported.
- en falling in the same cycle as a closing tick: en takes priority; no update and no strobe.
- Mid-frame reset: all state returns to reset values immediately; the partial frame is discarded.
- Steady generator input with the same DIV and clk gives exactly one sample per generator slot, so pw_out equals the generator's code (0..4094 exact, 4095 via saturation).
- Asynchronous or jittery input: the result is a slot-quantised duty estimate with no error flag. A single glitch shorter than one clock may or may not be counted.
- No combinational path from any input to any output.

Test Plan:
- Reset, en=1, pwm_in held 0 for 2 frames -> pw_valid pulses at clocks 12288 and 24576 (±sync latency, exact cycle checked against the model). pw_out=0, static_flag=1, pw_changed=0.
- Loop-back from a generator model, DIV=3, code 1000 (high for 1000 of 4096 slots) with arbitrary start phase -> every frame gives pw_out=1000 and static_flag=0. pw_changed=1 on the first frame only.
- pwm_in held 1 -> pw_out=4095 (saturated), static_flag=1. Then switch to code 1 -> next full frame pw_out=1, static_flag=0, pw_changed=1.
- Code changes 2000->3000 mid-frame -> the straddling frame reports a value between 2000 and 3000. The following frame reports 3000 exactly with pw_changed=1; later frames have pw_changed=0.
- Drop en mid-frame for 100 clocks, then re-raise -> no pw_valid during or at the disable. pw_out holds its old value. The next pw_valid comes exactly 12288 clocks after re-enable, with the correct code.
- Assert rst for 1 cycle mid-frame -> outputs are 0 immediately (asynchronously, before the next clk edge). The first post-reset pw_valid comes one full frame later. Repeat with DIV=1 and WIDTH=4: pw_valid every 16 clocks.
